// File: rtl/move_scheduler_if.sv
// Player-command bus between the board pins / VGA timing side and the game core.
// The scheduler uses the slave view; the driving environment uses the master view.
interface move_scheduler_if;
    logic btn_right;
    logic btn_left;
    logic btn_drop;
    logic frame_start;
    logic game_over;
    logic move_right;
    logic move_left;
    logic drop_piece;
    logic busy;

    modport slave (
        input  btn_right, btn_left, btn_drop, frame_start, game_over,
        output move_right, move_left, drop_piece, busy
    );

    modport master (
        output btn_right, btn_left, btn_drop, frame_start, game_over,
        input  move_right, move_left, drop_piece, busy
    );
endinterface

// File: rtl/move_scheduler.sv
// Debounces the player buttons and issues one frame-aligned, rate-limited
// command pulse per accepted press to the connect-four game core.
//
// state      | meaning
// IDLE       | no command pending, waiting for a debounced press
// WAIT_FRAME | command captured, holding it until the next frame_start
// ISSUE      | command pulse is on the outputs this cycle
// LOCKOUT    | counting frames before another command may be captured
module move_scheduler #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int LOCKOUT_FRAMES  = 4
) (
    input  logic            clk_25MHz,
    input  logic            rst_n,
    move_scheduler_if.slave bus
);
    localparam int               LK_W    = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0]  LK_LOAD = LK_W'(LOCKOUT_FRAMES);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ISSUE, LOCKOUT} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_RIGHT, CMD_LEFT, CMD_DROP} cmd_t;

    // Bit order for all per-button vectors: [0]=right, [1]=left, [2]=drop
    logic [2:0]       raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       stable;
    logic [2:0]       press;
    logic [CNT_W-1:0] db_cnt [3];

    state_t          state;
    cmd_t            pending;
    logic [LK_W-1:0] lk_cnt;
    logic            move_right_q;
    logic            move_left_q;
    logic            drop_piece_q;
    logic            busy_q;

    assign raw = {bus.btn_drop, bus.btn_left, bus.btn_right};

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // press is registered alongside the stable update, so it is a single-cycle
    // pulse and only fires on an accepted 0->1 change.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync_b[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync_b[i];
                        press[i]  <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= CMD_NONE;
            lk_cnt       <= '0;
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            drop_piece_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            drop_piece_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.game_over && (press != 3'b000)) begin
                        state  <= WAIT_FRAME;
                        busy_q <= 1'b1;
                        if (press[2]) begin
                            pending <= CMD_DROP;
                        end else if (press[1]) begin
                            pending <= CMD_LEFT;
                        end else begin
                            pending <= CMD_RIGHT;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (bus.game_over) begin
                        state   <= IDLE;
                        pending <= CMD_NONE;
                        busy_q  <= 1'b0;
                    end else if (bus.frame_start) begin
                        state        <= ISSUE;
                        move_right_q <= (pending == CMD_RIGHT);
                        move_left_q  <= (pending == CMD_LEFT);
                        drop_piece_q <= (pending == CMD_DROP);
                    end
                end
                ISSUE: begin
                    pending <= CMD_NONE;
                    if (LOCKOUT_FRAMES == 0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= LOCKOUT;
                        lk_cnt <= LK_LOAD;
                    end
                end
                LOCKOUT: begin
                    if (bus.frame_start) begin
                        if (lk_cnt <= LK_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            lk_cnt <= '0;
                        end else begin
                            lk_cnt <= lk_cnt - LK_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.move_right = move_right_q;
    assign bus.move_left  = move_left_q;
    assign bus.drop_piece = drop_piece_q;
    assign bus.busy       = busy_q;
endmodule
